// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - alu_control codes, multiply FSM states and op-class helpers
package mips_alu_pkg;

  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b011001;
  localparam logic [5:0] ALU_MADD  = 6'b011100;
  localparam logic [5:0] ALU_MADDU = 6'b011101;
  localparam logic [5:0] ALU_MFHI  = 6'b010000;
  localparam logic [5:0] ALU_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

  function automatic logic is_mult_op(input logic [5:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_MADD) || (code == ALU_MADDU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] code);
    return (code == ALU_MULT) || (code == ALU_MADD);
  endfunction

  function automatic logic is_acc_op(input logic [5:0] code);
    return (code == ALU_MADD) || (code == ALU_MADDU);
  endfunction

  function automatic logic is_mf_op(input logic [5:0] code);
    return (code == ALU_MFHI) || (code == ALU_MFLO);
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// rtl/mult_shift_add_core.sv - radix-2 shift-add magnitude multiplier with iteration counter
module mult_shift_add_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [XLEN-1:0]   i_mcand,
  input  logic [XLEN-1:0]   i_mplier,
  output logic [2*XLEN-1:0] o_product,
  output logic              o_last,
  output logic              o_mplier_zero
);

  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{XLEN{1'b0}}, i_mcand};
      r_acc    <= '0;
      r_mplier <= i_mplier;
      r_cnt    <= CNT_W'(XLEN);
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign o_product     = r_acc;
  // Asserted during the step that brings the counter to zero.
  assign o_last        = (r_cnt == CNT_W'(1));
  // Multiplier bits left after the current step are all zero.
  assign o_mplier_zero = (r_mplier[XLEN-1:1] == '0);

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - multi-cycle MULT/MULTU/MADD/MADDU with HI/LO; MULT_EARLY_TERM_EN enables early exit
module mult_hilo_unit
  import mips_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      alu_control,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef MULT_EARLY_TERM_EN
  localparam logic EARLY_TERM = 1'b1;
`else
  localparam logic EARLY_TERM = 1'b0;
`endif

  mult_state_e       r_state, w_next;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic [5:0]        r_op;
  logic              r_neg, r_done;
  logic              w_signed, w_accept, w_load, w_step, w_write;
  logic              w_last, w_mplier_zero;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [2*XLEN-1:0] w_product, w_prod_fixed, w_hilo_next;

  assign w_signed = is_signed_op(alu_control);
  // -2^(XLEN-1) negates to itself, which read as unsigned is the right magnitude.
  assign w_a_mag  = (w_signed && rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign w_b_mag  = (w_signed && rt_val[XLEN-1]) ? -rt_val : rt_val;
  assign w_accept = start && is_mult_op(alu_control) && (r_state == IDLE);

  mult_shift_add_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_mcand      (w_a_mag),
    .i_mplier     (w_b_mag),
    .o_product    (w_product),
    .o_last       (w_last),
    .o_mplier_zero(w_mplier_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (EARLY_TERM && (w_b_mag == '0)) ? FINISH : RUN;
      RUN:     if (w_last || (EARLY_TERM && w_mplier_zero)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    w_load  = w_accept;
    w_step  = (r_state == RUN);
    w_write = (r_state == FINISH);
  end

  assign w_prod_fixed = r_neg ? -w_product : w_product;
  assign w_hilo_next  = is_acc_op(r_op) ? ({r_hi, r_lo} + w_prod_fixed) : w_prod_fixed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_op   <= '0;
      r_neg  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_load) begin
        r_op  <= alu_control;
        r_neg <= w_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
      end
      if (w_write) {r_hi, r_lo} <= w_hilo_next;
    end
  end

  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = busy && start && (is_mult_op(alu_control) || is_mf_op(alu_control));

  always_comb begin
    mf_result = '0;
    if (alu_control == ALU_MFHI)      mf_result = r_hi;
    else if (alu_control == ALU_MFLO) mf_result = r_lo;
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - directed self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;
  import mips_alu_pkg::*;

  localparam logic [5:0] ALU_NOP = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_control;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done;
  logic [31:0] hi, lo, mf_result;

  int n_checks = 0;
  int n_fails  = 0;

  mult_hilo_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_control(alu_control),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mf_result  (mf_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one mult op and wait (bounded) for done; lat = posedges from issue to done cycle.
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; alu_control = code; rs_val = a; rt_val = b;
    lat = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin
        #1; start = 1'b0; alu_control = ALU_NOP;
      end
      @(negedge clk);
      if (done) seen = 1;
    end
  endtask

  int lat;
  int k;
  int done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_control = ALU_NOP; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_hi", hi, 0);
    check_eq("reset_lo", lo, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    rst_n = 1'b1;

    // MULT -3 * 7
    run_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7, lat);
    check_eq("mult_neg_lat", lat, 34);
    check_eq("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check_eq("mult_neg_busy_done", busy, 0);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);

    // MULTU 0xFFFFFFFF * 2
    run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, lat);
    check_eq("multu_lat", lat, 34);
    check_eq("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    // MULT 5*6 with MFLO and a second MULT issued while busy
    @(posedge clk); #1;
    start = 1'b1; alu_control = ALU_MULT; rs_val = 32'd5; rt_val = 32'd6;
    done_seen = 0;
    k = 0;
    while (!done_seen && k < 100) begin
      @(posedge clk);
      k++;
      #1;
      if (k == 1)  begin start = 1'b0; alu_control = ALU_NOP; end
      if (k == 10) begin start = 1'b1; alu_control = ALU_MFLO; end
      if (k == 12) begin alu_control = ALU_MULT; rs_val = 32'd100; rt_val = 32'd100; end
      if (k == 13) alu_control = ALU_MFLO;
      @(negedge clk);
      if (done) done_seen = 1;
      else if (k >= 10) begin
        check_eq("busy_stall", stall, 1);
        if (k != 12) check_eq("busy_mflo_old", mf_result, 32'hFFFF_FFFE);
      end
    end
    check_eq("inflight_lat", k, 34);
    check_eq("inflight_hilo", {hi, lo}, 64'd30);
    check_eq("done_cycle_mflo_new", mf_result, 30);
    check_eq("done_cycle_stall", stall, 0);
    #2; start = 1'b0; alu_control = ALU_NOP;

    // MADDU carry from LO into HI
    run_op(ALU_MULTU, 32'd1, 32'hFFFF_FFFF, lat);
    check_eq("setup_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    run_op(ALU_MADDU, 32'd1, 32'd1, lat);
    check_eq("maddu_lat", lat, 34);
    check_eq("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

    // MFHI/MFLO and an unrelated code while idle
    @(posedge clk); #1;
    start = 1'b1; alu_control = ALU_MFHI;
    @(negedge clk);
    check_eq("mfhi_val", mf_result, 1);
    check_eq("mfhi_stall", stall, 0);
    @(posedge clk); #1;
    alu_control = ALU_MFLO;
    @(negedge clk);
    check_eq("mf_no_busy", busy, 0);
    check_eq("mflo_val", mf_result, 0);
    @(posedge clk); #1;
    alu_control = ALU_NOP;
    @(negedge clk);
    check_eq("nop_mf", mf_result, 0);
    check_eq("nop_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("nop_busy", busy, 0);

    // Most negative squared
    run_op(ALU_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    check_eq("minneg_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // Signed MADD of -2*3 onto 0x40000000_00000000
    run_op(ALU_MADD, 32'hFFFF_FFFE, 32'd3, lat);
    check_eq("madd_hilo", {hi, lo}, 64'h3FFF_FFFF_FFFF_FFFA);

    // Reset mid-flight
    @(posedge clk); #1;
    start = 1'b1; alu_control = ALU_MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; alu_control = ALU_NOP;
    repeat (14) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_eq("rst_no_done", done_seen, 0);
    check_eq("rst_hilo_after", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
